i2c_bus_arbiter: RTL and testbench
==================================

I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing the I2C master port; 2..4 supported.
REQ-002 SHALL have parameter FREE_CYC, default 8: bus-free iClk cycles required before a new grant.
REQ-003 SHALL have parameter TO_CYC, default 4096: timeout cycles, 16-bit counter.
REQ-004 SHALL have port iClk, input, 1 bit: the single clock; all state on its rising edge.
REQ-005 SHALL have port iRstn, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port iReq, input, NREQ bits: level request per requester; held until done.
REQ-007 SHALL have port oGnt, output, NREQ bits: one-hot grant, registered.
REQ-008 SHALL have port oGntId, output, 2 bits: binary index of current or last grant.
REQ-009 SHALL have port iScl, input, 1 bit: monitored SCL, asynchronous to iClk.
REQ-010 SHALL have port iSda, input, 1 bit: monitored SDA, asynchronous to iClk.
REQ-011 SHALL have port oBusy, output, 1 bit: bus is between START and STOP, whoever drives it.
REQ-012 SHALL have port oTimeout, output, 1 bit: one-cycle pulse when a grant is force-released.

Function
REQ-013 SHALL pass iScl and iSda through 2-flop synchronizers plus one history flop; all detection uses the synchronized values.
REQ-014 SHALL detect START as synced SDA 1->0 while synced SCL is 1 in both the current and previous sample.
REQ-015 SHALL detect STOP as synced SDA 0->1 while synced SCL is 1 in both the current and previous sample.
REQ-016 SHALL set oBusy on START and clear it on STOP; a repeated START leaves it set.
REQ-017 SHALL run a free counter that clears when either synced line is 0 or oBusy is 1, increments otherwise, and saturates at FREE_CYC.
REQ-018 SHALL implement an FSM with states IDLE, WAIT_START, ACTIVE and HOLDOFF.
REQ-019 IDLE: when the free counter equals FREE_CYC, oBusy is 0 and any iReq bit is set, SHALL select the first set bit searching upward from pointer rr_ptr with wrap; set oGnt and oGntId next cycle; go to WAIT_START.
REQ-020 WAIT_START: on START SHALL go to ACTIVE.
REQ-021 WAIT_START: if the granted iReq drops before START, SHALL go to HOLDOFF with no oTimeout pulse.
REQ-022 WAIT_START: if TO_CYC cycles pass with no START, SHALL pulse oTimeout and go to HOLDOFF.
REQ-023 ACTIVE: on STOP SHALL go to HOLDOFF.
REQ-024 ACTIVE: if synced SCL stays 0 for TO_CYC consecutive cycles, SHALL pulse oTimeout and go to HOLDOFF.
REQ-025 ACTIVE: if the granted iReq drops, SHALL ignore it and wait for STOP or timeout; the grant is never revoked mid-transaction.
REQ-026 The timeout counter SHALL clear on every state entry; in ACTIVE it also clears whenever synced SCL is 1.
REQ-027 HOLDOFF: oGnt SHALL be 0; rr_ptr SHALL become (granted index + 1) mod NREQ; SHALL return to IDLE next cycle, so the re-grant waits on REQ-017.
REQ-028 A START seen in IDLE (foreign master) SHALL block grants until STOP plus FREE_CYC free cycles.
REQ-029 Simultaneous START and granted-iReq drop in WAIT_START: START wins, go to ACTIVE.
REQ-030 oGnt SHALL never have more than one bit set, and SHALL be set only in WAIT_START or ACTIVE.
REQ-031 Grant latency SHALL be exactly 1 cycle from the IDLE cycle meeting REQ-019 to oGnt asserting.

Reset
REQ-032 On iRstn low, SHALL asynchronously reset: state IDLE, oGnt 0, oGntId 0, oBusy 0, oTimeout 0, rr_ptr 0, all counters 0, synchronizer and history flops 1 (bus idle).
REQ-033 Reset mid-transaction SHALL drop the grant immediately; after release, a grant requires FREE_CYC free cycles.

Verification
REQ-034 SHALL verify round-robin: iReq=4'b1111, full START..STOP per grant -> grants in order 0,1,2,3,0 with oGntId 0,1,2,3,0.
REQ-035 SHALL verify start timeout: iReq[2]=1, bus never starts -> oGnt=4'b0100 for TO_CYC cycles, then a one-cycle oTimeout and oGnt=0.
REQ-036 SHALL verify SCL stuck low: SCL held low in ACTIVE for TO_CYC cycles -> oTimeout pulse, oGnt=0, rr_ptr advances.
REQ-037 SHALL verify a foreign master: START in IDLE with iReq[1]=1 -> oBusy=1, no grant until STOP plus 8 free cycles, then oGnt=4'b0010.
REQ-038 SHALL verify a repeated START: START, Sr, STOP under grant 0 -> a single grant, oBusy high throughout, release only after STOP.
REQ-039 SHALL verify reset mid-ACTIVE: iRstn pulsed low -> oGnt=0 and oBusy=0 asynchronously, rr_ptr=0.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter granting one of NREQ requesters access to a shared I2C master port.
// Monitors SCL/SDA for START/STOP, enforces a bus-free gap, and force-releases stalled grants.
module i2c_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int FREE_CYC = 8,
    parameter int TO_CYC   = 4096
) (
    input  logic            iClk,
    input  logic            iRstn,
    input  logic [NREQ-1:0] iReq,
    output logic [NREQ-1:0] oGnt,
    output logic [1:0]      oGntId,
    input  logic            iScl,
    input  logic            iSda,
    output logic            oBusy,
    output logic            oTimeout
);

    // state      | meaning
    // IDLE       | waiting for a free bus and a request
    // WAIT_START | grant issued, waiting for the owner's START
    // ACTIVE     | owner's transaction in progress, wait for STOP
    // HOLDOFF    | grant dropped, advance round-robin pointer
    typedef enum logic [1:0] {IDLE, WAIT_START, ACTIVE, HOLDOFF} state_t;

    localparam int          FW       = $clog2(FREE_CYC + 1);
    localparam logic [FW-1:0] FREE_MAX = FW'(FREE_CYC);
    localparam logic [15:0] TO_LAST  = 16'(TO_CYC - 1);
    localparam logic [1:0]  LAST_ID  = 2'(NREQ - 1);

    state_t          state, state_d;
    logic            scl_s1, scl_s2, scl_h;
    logic            sda_s1, sda_s2, sda_h;
    logic            start_det, stop_det;
    logic [FW-1:0]   free_cnt;
    logic [15:0]     to_cnt;
    logic [1:0]      rr_ptr, ptr_d;
    logic [1:0]      sel_id, id_d;
    logic            sel_vld;
    logic [NREQ-1:0] gnt_d;
    logic            tout_d;
    logic            bus_free, grant_ok, req_held, to_hit;

    // Lines reset to 1 so the bus looks idle straight out of reset.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            {scl_s1, scl_s2, scl_h} <= 3'b111;
            {sda_s1, sda_s2, sda_h} <= 3'b111;
        end else begin
            {scl_s1, scl_s2, scl_h} <= {iScl, scl_s1, scl_s2};
            {sda_s1, sda_s2, sda_h} <= {iSda, sda_s1, sda_s2};
        end
    end

    assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            oBusy <= 1'b0;
        end else if (start_det) begin
            oBusy <= 1'b1;
        end else if (stop_det) begin
            oBusy <= 1'b0;
        end
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            free_cnt <= '0;
        end else if (!scl_s2 || !sda_s2 || oBusy) begin
            free_cnt <= '0;
        end else if (free_cnt != FREE_MAX) begin
            free_cnt <= free_cnt + 1'b1;
        end
    end

    // Walk downward so the requester closest above rr_ptr is the last (winning) assignment.
    always_comb begin
        int idx;
        idx     = 0;
        sel_id  = rr_ptr;
        sel_vld = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (iReq[idx]) begin
                sel_vld = 1'b1;
                sel_id  = 2'(idx);
            end
        end
    end

    assign bus_free = (free_cnt == FREE_MAX) & ~oBusy;
    assign grant_ok = bus_free & ~start_det & sel_vld;
    assign req_held = |(iReq & oGnt);
    assign to_hit   = (to_cnt == TO_LAST);

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:       if (grant_ok) state_d = WAIT_START;
            WAIT_START: begin
                if (start_det)     state_d = ACTIVE;
                else if (!req_held) state_d = HOLDOFF;
                else if (to_hit)    state_d = HOLDOFF;
            end
            ACTIVE: begin
                if (stop_det)                state_d = HOLDOFF;
                else if (!scl_s2 && to_hit)  state_d = HOLDOFF;
            end
            HOLDOFF:    state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d  = oGnt;
        id_d   = oGntId;
        ptr_d  = rr_ptr;
        tout_d = 1'b0;
        case (state)
            IDLE: begin
                if (grant_ok) begin
                    gnt_d         = '0;
                    gnt_d[sel_id] = 1'b1;
                    id_d          = sel_id;
                end
            end
            WAIT_START: begin
                if (!start_det && req_held && to_hit) tout_d = 1'b1;
                if (state_d == HOLDOFF) gnt_d = '0;
            end
            ACTIVE: begin
                if (!stop_det && !scl_s2 && to_hit) tout_d = 1'b1;
                if (state_d == HOLDOFF) gnt_d = '0;
            end
            HOLDOFF: begin
                gnt_d = '0;
                ptr_d = (oGntId == LAST_ID) ? 2'd0 : oGntId + 2'd1;
            end
            default: gnt_d = '0;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            oGnt     <= '0;
            oGntId   <= '0;
            rr_ptr   <= '0;
            oTimeout <= 1'b0;
        end else begin
            oGnt     <= gnt_d;
            oGntId   <= id_d;
            rr_ptr   <= ptr_d;
            oTimeout <= tout_d;
        end
    end

    // Restarts on every state change; in ACTIVE only consecutive SCL-low cycles count.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            to_cnt <= '0;
        end else if (state_d != state) begin
            to_cnt <= '0;
        end else if (state == ACTIVE && scl_s2) begin
            to_cnt <= '0;
        end else if (state == WAIT_START || state == ACTIVE) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: round-robin order, timeouts, foreign master,
// repeated START and asynchronous reset, with hand-computed expectations.
module tb_i2c_bus_arbiter;

    localparam int NREQ     = 4;
    localparam int FREE_CYC = 8;
    localparam int TO_CYC   = 32;

    logic            iClk = 1'b0;
    logic            iRstn;
    logic [NREQ-1:0] iReq;
    logic [NREQ-1:0] oGnt;
    logic [1:0]      oGntId;
    logic            iScl, iSda;
    logic            oBusy, oTimeout;

    int n_checks = 0;
    int n_err    = 0;

    i2c_bus_arbiter #(.NREQ(NREQ), .FREE_CYC(FREE_CYC), .TO_CYC(TO_CYC)) dut (
        .iClk(iClk), .iRstn(iRstn), .iReq(iReq), .oGnt(oGnt), .oGntId(oGntId),
        .iScl(iScl), .iSda(iSda), .oBusy(oBusy), .oTimeout(oTimeout)
    );

    always #5 iClk = ~iClk;

    task automatic tick(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input string tag, input int max);
        int n;
        n = 0;
        while (oGnt == '0 && n < max) begin
            tick(1);
            n++;
        end
        chk(tag, {31'd0, oGnt != '0}, 32'd1);
    endtask

    // Full owner transaction: START, one data bit pair, STOP.
    task automatic do_txn(input string tag, input logic [3:0] exp_gnt);
        iSda = 1'b0; tick(4);
        iScl = 1'b0; tick(4);
        chk({tag, "_busy"}, {31'd0, oBusy}, 32'd1);
        chk({tag, "_held"}, {28'd0, oGnt}, {28'd0, exp_gnt});
        iSda = 1'b1; tick(4);
        iScl = 1'b1; tick(4);
        iScl = 1'b0; tick(4);
        iSda = 1'b0; tick(4);
        iScl = 1'b1; tick(4);
        iSda = 1'b1; tick(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          e;
        logic [3:0]  eg;
        bit          seen;

        iRstn = 1'b0; iScl = 1'b1; iSda = 1'b1; iReq = 4'b1111;
        tick(3);
        chk("rst_gnt",  {28'd0, oGnt}, 32'd0);
        chk("rst_id",   {30'd0, oGntId}, 32'd0);
        chk("rst_busy", {31'd0, oBusy}, 32'd0);
        chk("rst_tout", {31'd0, oTimeout}, 32'd0);

        // Grant after exactly FREE_CYC free cycles plus one registered cycle.
        iRstn = 1'b1;
        tick(8);
        chk("init_nogrant", {28'd0, oGnt}, 32'd0);
        tick(1);
        chk("init_grant", {28'd0, oGnt}, 32'h1);

        // Round-robin 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            e  = k % 4;
            eg = 4'b0001 << e;
            chk("rr_gnt", {28'd0, oGnt}, {28'd0, eg});
            chk("rr_id",  {30'd0, oGntId}, e);
            do_txn("rr_txn", eg);
            if (k < 4) wait_gnt("rr_wait", 60);
        end
        iReq = 4'b0000;
        tick(20);
        chk("rr_released", {28'd0, oGnt}, 32'd0);

        // Repeated START under grant 0; drop of request during ACTIVE is ignored
        iReq = 4'b0001;
        wait_gnt("sr_wait", 30);
        chk("sr_gnt", {28'd0, oGnt}, 32'h1);
        iSda = 1'b0; tick(4);
        chk("sr_busy0", {31'd0, oBusy}, 32'd1);
        iScl = 1'b0; tick(4);
        iSda = 1'b1; tick(4);
        iScl = 1'b1; tick(4);
        iSda = 1'b0; tick(4);
        chk("sr_busy1", {31'd0, oBusy}, 32'd1);
        chk("sr_gnt1",  {28'd0, oGnt}, 32'h1);
        iReq = 4'b0000;
        iScl = 1'b0; tick(4);
        chk("sr_drop_ignored", {28'd0, oGnt}, 32'h1);
        iScl = 1'b1; tick(4);
        chk("sr_busy2", {31'd0, oBusy}, 32'd1);
        iSda = 1'b1; tick(1);
        chk("sr_gnt_prestop", {28'd0, oGnt}, 32'h1);
        tick(5);
        chk("sr_release", {28'd0, oGnt}, 32'd0);
        chk("sr_busy_clr", {31'd0, oBusy}, 32'd0);
        tick(20);
        chk("sr_no_regrant", {28'd0, oGnt}, 32'd0);

        // Start timeout: only requester 2, bus never starts
        iReq = 4'b0100;
        wait_gnt("to_wait", 30);
        chk("to_gnt", {28'd0, oGnt}, 32'h4);
        chk("to_id",  {30'd0, oGntId}, 32'd2);
        n = 1;
        while (n < TO_CYC + 10) begin
            tick(1);
            if (oGnt == 4'b0100) n++;
            else break;
        end
        chk("to_held_cycles", n, TO_CYC);
        chk("to_pulse",    {31'd0, oTimeout}, 32'd1);
        chk("to_gnt_drop", {28'd0, oGnt}, 32'd0);
        iReq = 4'b0000;
        tick(1);
        chk("to_pulse_end", {31'd0, oTimeout}, 32'd0);
        tick(4);

        // SCL stuck low in ACTIVE; pointer is now 3
        iReq = 4'b1111;
        wait_gnt("stk_wait", 30);
        chk("stk_id", {30'd0, oGntId}, 32'd3);
        iSda = 1'b0; tick(4);
        iScl = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < TO_CYC + 10; i++) begin
            tick(1);
            if (oTimeout) begin
                seen = 1'b1;
                break;
            end
        end
        chk("stk_pulse", {31'd0, seen}, 32'd1);
        chk("stk_gnt",   {28'd0, oGnt}, 32'd0);
        chk("stk_busy",  {31'd0, oBusy}, 32'd1);
        iScl = 1'b1; tick(4);
        iSda = 1'b1;
        wait_gnt("stk_regrant", 40);
        chk("stk_ptr_wrap", {30'd0, oGntId}, 32'd0);
        chk("stk_gnt0", {28'd0, oGnt}, 32'h1);

        // Request drop in WAIT_START: release without timeout
        iReq = 4'b0000;
        tick(1);
        chk("drop_gnt",  {28'd0, oGnt}, 32'd0);
        chk("drop_tout", {31'd0, oTimeout}, 32'd0);
        tick(1);
        chk("drop_tout2", {31'd0, oTimeout}, 32'd0);
        tick(12);

        // Foreign master START in IDLE blocks grants until STOP + FREE_CYC
        iSda = 1'b0; tick(4);
        chk("fm_busy", {31'd0, oBusy}, 32'd1);
        iReq = 4'b0010;
        tick(10);
        chk("fm_blocked", {28'd0, oGnt}, 32'd0);
        iScl = 1'b0; tick(4);
        iScl = 1'b1; tick(4);
        chk("fm_blocked2", {28'd0, oGnt}, 32'd0);
        iSda = 1'b1;
        tick(11);
        chk("fm_nogrant_yet", {28'd0, oGnt}, 32'd0);
        chk("fm_busy_clr", {31'd0, oBusy}, 32'd0);
        tick(1);
        chk("fm_grant", {28'd0, oGnt}, 32'h2);

        // Asynchronous reset mid-ACTIVE
        iSda = 1'b0; tick(4);
        chk("rstm_busy", {31'd0, oBusy}, 32'd1);
        chk("rstm_gnt",  {28'd0, oGnt}, 32'h2);
        #3;
        iRstn = 1'b0;
        #1;
        chk("rstm_async_gnt",  {28'd0, oGnt}, 32'd0);
        chk("rstm_async_busy", {31'd0, oBusy}, 32'd0);
        iSda = 1'b1;
        iReq = 4'b1111;
        tick(2);
        iRstn = 1'b1;
        tick(8);
        chk("rstm_nogrant", {28'd0, oGnt}, 32'd0);
        tick(1);
        chk("rstm_ptr0_gnt", {28'd0, oGnt}, 32'h1);
        chk("rstm_ptr0_id",  {30'd0, oGntId}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
